// File: rtl/rr_lane_checker.sv
// Round-robin checker: spreads DUT transactions over NUM_LANES fixed-latency
// lanes and compares each DUT result against a golden add/sub/mul result.
module rr_lane_checker #(
    parameter int WIDTH     = 32,
    parameter int NUM_LANES = 4,
    parameter int LANE_LAT  = 3,
    parameter int MODE      = 0,
    parameter int CNT_WIDTH = 16,
    parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [WIDTH-1:0]     i_dut_o,
    input  logic                 i_clear,
    output logic                 o_done,
    output logic                 o_event,
    output logic [LANE_W-1:0]    o_lane,
    output logic [CNT_WIDTH-1:0] o_txn_count,
    output logic [CNT_WIDTH-1:0] o_err_count,
    output logic                 o_first_valid,
    output logic [WIDTH-1:0]     o_first_a,
    output logic [WIDTH-1:0]     o_first_b,
    output logic [WIDTH-1:0]     o_first_dut,
    output logic [WIDTH-1:0]     o_first_exp
);

    localparam int CW = $clog2(LANE_LAT + 1);
    typedef logic [CW-1:0] lat_t;
    localparam lat_t LAT_INIT = lat_t'(LANE_LAT);
    localparam lat_t LAT_ONE  = lat_t'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_LANES-1:0] busy_q;
    lat_t                 cnt_q [NUM_LANES];
    logic [WIDTH-1:0]     a_q   [NUM_LANES];
    logic [WIDTH-1:0]     b_q   [NUM_LANES];
    logic [WIDTH-1:0]     dut_q [NUM_LANES];
    logic [LANE_W-1:0]    ptr_q, ptr_d;

    logic                 done_q, event_q;
    logic [LANE_W-1:0]    lane_q;
    logic [CNT_WIDTH-1:0] txn_q, txn_d, err_q, err_d;
    logic                 first_valid_q;
    logic [WIDTH-1:0]     first_a_q, first_b_q, first_dut_q, first_exp_q;

    logic                 ready;
    logic                 accept;
    logic                 ret_any;
    logic [LANE_W-1:0]    ret_idx;
    logic [WIDTH-1:0]     golden;
    logic                 mismatch;

    function automatic logic [WIDTH-1:0] golden_fn(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (MODE)
            1:       r = a - b;
            2:       r = a * b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    // A lane whose counter reads 1 retires on this edge and can take new work.
    assign ready  = ~busy_q[ptr_q] | (cnt_q[ptr_q] == LAT_ONE);
    assign accept = i_valid & ready;
    assign ptr_d  = (ptr_q == LANE_W'(NUM_LANES - 1)) ? '0 : ptr_q + 1'b1;

    // Equal latency with one accept per cycle guarantees at most one retiring lane.
    always_comb begin
        ret_any = 1'b0;
        ret_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (busy_q[i] && cnt_q[i] == LAT_ONE) begin
                ret_any = 1'b1;
                ret_idx = LANE_W'(i);
            end
        end
    end

    assign golden   = golden_fn(a_q[ret_idx], b_q[ret_idx]);
    assign mismatch = ret_any && (golden != dut_q[ret_idx]);

    always_comb begin
        txn_d = txn_q;
        err_d = err_q;
        if (ret_any && txn_q != CNT_MAX) txn_d = txn_q + 1'b1;
        if (mismatch && err_q != CNT_MAX) err_d = err_q + 1'b1;
    end

    // NOTE: lane storage is reset too, so an idle lane never exposes stale operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            ptr_q  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                dut_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (accept && ptr_q == LANE_W'(i)) begin
                    busy_q[i] <= 1'b1;
                    cnt_q[i]  <= LAT_INIT;
                    a_q[i]    <= i_a;
                    b_q[i]    <= i_b;
                    dut_q[i]  <= i_dut_o;
                end else if (busy_q[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                    if (cnt_q[i] == LAT_ONE) busy_q[i] <= 1'b0;
                end
            end
            if (accept) ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q        <= 1'b0;
            event_q       <= 1'b0;
            lane_q        <= '0;
            txn_q         <= '0;
            err_q         <= '0;
            first_valid_q <= 1'b0;
            first_a_q     <= '0;
            first_b_q     <= '0;
            first_dut_q   <= '0;
            first_exp_q   <= '0;
        end else begin
            done_q  <= ret_any;
            event_q <= mismatch;
            lane_q  <= ret_idx;
            // Clear takes priority over a coinciding retire for the counters and capture.
            if (i_clear) begin
                txn_q         <= '0;
                err_q         <= '0;
                first_valid_q <= 1'b0;
                first_a_q     <= '0;
                first_b_q     <= '0;
                first_dut_q   <= '0;
                first_exp_q   <= '0;
            end else begin
                txn_q <= txn_d;
                err_q <= err_d;
                if (mismatch && !first_valid_q) begin
                    first_valid_q <= 1'b1;
                    first_a_q     <= a_q[ret_idx];
                    first_b_q     <= b_q[ret_idx];
                    first_dut_q   <= dut_q[ret_idx];
                    first_exp_q   <= golden;
                end
            end
        end
    end

    assign o_ready       = ready;
    assign o_done        = done_q;
    assign o_event       = event_q;
    assign o_lane        = lane_q;
    assign o_txn_count   = txn_q;
    assign o_err_count   = err_q;
    assign o_first_valid = first_valid_q;
    assign o_first_a     = first_a_q;
    assign o_first_b     = first_b_q;
    assign o_first_dut   = first_dut_q;
    assign o_first_exp   = first_exp_q;

endmodule

// File: tb/tb_rr_lane_checker.sv
// Directed bench for rr_lane_checker: add/sub/mul instances with 4 lanes and
// latency 3, plus a 2-lane, latency-4, 2-bit-counter instance for stalls and saturation.
module tb_rr_lane_checker;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] a, b, dut;
    logic v_add, v_sub, v_mul, v_n2;
    logic clr_add, clr_n2;

    int checks = 0;
    int errors = 0;

    // Outputs of the 4-lane instances (index 0 add, 1 sub, 2 mul)
    logic       r_x  [3];
    logic       d_x  [3];
    logic       e_x  [3];
    logic [1:0] l_x  [3];
    logic [15:0] t_x [3];
    logic [15:0] er_x[3];
    logic       fv_x [3];
    logic [7:0] fa_x [3], fb_x [3], fd_x [3], fe_x [3];

    // Outputs of the 2-lane instance
    logic       r_n2, d_n2, e_n2, l_n2, fv_n2;
    logic [1:0] t_n2, er_n2;
    logic [7:0] fa_n2, fb_n2, fd_n2, fe_n2;

    always #5 clk = ~clk;

    rr_lane_checker #(.WIDTH(8), .NUM_LANES(4), .LANE_LAT(3), .MODE(0), .CNT_WIDTH(16)) u_add (
        .clk(clk), .reset(reset), .i_valid(v_add), .o_ready(r_x[0]),
        .i_a(a), .i_b(b), .i_dut_o(dut), .i_clear(clr_add),
        .o_done(d_x[0]), .o_event(e_x[0]), .o_lane(l_x[0]),
        .o_txn_count(t_x[0]), .o_err_count(er_x[0]), .o_first_valid(fv_x[0]),
        .o_first_a(fa_x[0]), .o_first_b(fb_x[0]), .o_first_dut(fd_x[0]), .o_first_exp(fe_x[0]));

    rr_lane_checker #(.WIDTH(8), .NUM_LANES(4), .LANE_LAT(3), .MODE(1), .CNT_WIDTH(16)) u_sub (
        .clk(clk), .reset(reset), .i_valid(v_sub), .o_ready(r_x[1]),
        .i_a(a), .i_b(b), .i_dut_o(dut), .i_clear(1'b0),
        .o_done(d_x[1]), .o_event(e_x[1]), .o_lane(l_x[1]),
        .o_txn_count(t_x[1]), .o_err_count(er_x[1]), .o_first_valid(fv_x[1]),
        .o_first_a(fa_x[1]), .o_first_b(fb_x[1]), .o_first_dut(fd_x[1]), .o_first_exp(fe_x[1]));

    rr_lane_checker #(.WIDTH(8), .NUM_LANES(4), .LANE_LAT(3), .MODE(2), .CNT_WIDTH(16)) u_mul (
        .clk(clk), .reset(reset), .i_valid(v_mul), .o_ready(r_x[2]),
        .i_a(a), .i_b(b), .i_dut_o(dut), .i_clear(1'b0),
        .o_done(d_x[2]), .o_event(e_x[2]), .o_lane(l_x[2]),
        .o_txn_count(t_x[2]), .o_err_count(er_x[2]), .o_first_valid(fv_x[2]),
        .o_first_a(fa_x[2]), .o_first_b(fb_x[2]), .o_first_dut(fd_x[2]), .o_first_exp(fe_x[2]));

    rr_lane_checker #(.WIDTH(8), .NUM_LANES(2), .LANE_LAT(4), .MODE(0), .CNT_WIDTH(2)) u_n2 (
        .clk(clk), .reset(reset), .i_valid(v_n2), .o_ready(r_n2),
        .i_a(a), .i_b(b), .i_dut_o(dut), .i_clear(clr_n2),
        .o_done(d_n2), .o_event(e_n2), .o_lane(l_n2),
        .o_txn_count(t_n2), .o_err_count(er_n2), .o_first_valid(fv_n2),
        .o_first_a(fa_n2), .o_first_b(fb_n2), .o_first_dut(fd_n2), .o_first_exp(fe_n2));

    typedef struct {
        int         inst;
        logic [7:0] a, b, dut;
        logic       ev;
        int         lane, txn, err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_valid(input int inst, input logic v);
        case (inst)
            0: v_add = v;
            1: v_sub = v;
            default: v_mul = v;
        endcase
    endtask

    initial begin
        int n_done;

        vecs[0] = '{0,   3,   4,   7, 1'b0, 0, 1, 0};
        vecs[1] = '{0,   3,   4,   8, 1'b1, 1, 2, 1};
        vecs[2] = '{0,   1,   1,   5, 1'b1, 2, 3, 2};
        vecs[3] = '{0, 200, 100,  44, 1'b0, 3, 4, 2};
        vecs[4] = '{0, 255,   1,   0, 1'b0, 0, 5, 2};
        vecs[5] = '{1,   5,  10, 251, 1'b0, 0, 1, 0};
        vecs[6] = '{1,   0,   1, 255, 1'b0, 1, 2, 0};
        vecs[7] = '{2,  16,  17,  16, 1'b0, 0, 1, 0};
        vecs[8] = '{2,  16,  17,   0, 1'b1, 1, 2, 1};
        vecs[9] = '{2, 255, 255,   1, 1'b0, 2, 3, 1};

        reset = 1'b1;
        v_add = 1'b0; v_sub = 1'b0; v_mul = 1'b0; v_n2 = 1'b0;
        clr_add = 1'b0; clr_n2 = 1'b0;
        a = '0; b = '0; dut = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("reset_ready",  32'(r_x[0]), 1);
        check("reset_done",   32'(d_x[0]), 0);
        check("reset_lane",   32'(l_x[0]), 0);
        check("reset_txn",    32'(t_x[0]), 0);
        check("reset_err",    32'(er_x[0]), 0);
        check("reset_fvalid", 32'(fv_x[0]), 0);
        check("reset_n2_ready", 32'(r_n2), 1);

        // Single transactions, each retired exactly three edges after accept
        for (int i = 0; i < 10; i++) begin
            int s;
            s = vecs[i].inst;
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; dut = vecs[i].dut;
            set_valid(s, 1'b1);
            @(negedge clk);
            set_valid(s, 1'b0);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_early_done", i), 32'(d_x[s]), 0);
            @(negedge clk);
            check($sformatf("v%0d_done", i),  32'(d_x[s]), 1);
            check($sformatf("v%0d_event", i), 32'(e_x[s]), 32'(vecs[i].ev));
            check($sformatf("v%0d_lane", i),  32'(l_x[s]), 32'(vecs[i].lane));
            check($sformatf("v%0d_txn", i),   32'(t_x[s]), 32'(vecs[i].txn));
            check($sformatf("v%0d_err", i),   32'(er_x[s]), 32'(vecs[i].err));
            @(negedge clk);
            check($sformatf("v%0d_pulse_end", i), 32'(d_x[s]), 0);
        end

        check("add_first_valid", 32'(fv_x[0]), 1);
        check("add_first_a",     32'(fa_x[0]), 3);
        check("add_first_b",     32'(fb_x[0]), 4);
        check("add_first_dut",   32'(fd_x[0]), 8);
        check("add_first_exp",   32'(fe_x[0]), 7);
        check("sub_first_valid", 32'(fv_x[1]), 0);
        check("mul_first_dut",   32'(fd_x[2]), 0);
        check("mul_first_exp",   32'(fe_x[2]), 16);

        // Two lanes, latency 4: valid held for 8 cycles, all mismatching (1+1 vs 0)
        a = 8'd1; b = 8'd1; dut = 8'd0;
        for (int k = 0; k < 12; k++) begin
            logic exp_done;
            @(negedge clk);
            if (k < 8) check($sformatf("n2_ready_c%0d", k), 32'(r_n2), 32'((k % 4) < 2));
            exp_done = (k == 5) || (k == 6) || (k == 9) || (k == 10);
            check($sformatf("n2_done_c%0d", k), 32'(d_n2), 32'(exp_done));
            if (exp_done) check($sformatf("n2_lane_c%0d", k), 32'(l_n2), 32'((k == 6) || (k == 10)));
            v_n2 = (k < 8);
        end
        check("n2_txn_sat4",  32'(t_n2), 3);
        check("n2_err_sat4",  32'(er_n2), 3);
        check("n2_fvalid",    32'(fv_n2), 1);
        check("n2_first_exp", 32'(fe_n2), 2);

        // Fifth mismatch: counters stay saturated
        @(negedge clk);
        v_n2 = 1'b1;
        @(negedge clk);
        v_n2 = 1'b0;
        repeat (4) @(negedge clk);
        check("n2_5_done",  32'(d_n2), 1);
        check("n2_5_event", 32'(e_n2), 1);
        check("n2_5_txn",   32'(t_n2), 3);
        check("n2_5_err",   32'(er_n2), 3);

        // Sixth mismatch with clear on its retire edge
        @(negedge clk);
        v_n2 = 1'b1;
        @(negedge clk);
        v_n2 = 1'b0;
        repeat (3) @(negedge clk);
        clr_n2 = 1'b1;
        @(negedge clk);
        clr_n2 = 1'b0;
        check("n2_clr_done",   32'(d_n2), 1);
        check("n2_clr_event",  32'(e_n2), 1);
        check("n2_clr_lane",   32'(l_n2), 1);
        check("n2_clr_txn",    32'(t_n2), 0);
        check("n2_clr_err",    32'(er_n2), 0);
        check("n2_clr_fvalid", 32'(fv_n2), 0);
        check("n2_clr_fdut",   32'(fd_n2), 0);

        // Reset one cycle after two back-to-back accepts discards them
        @(negedge clk);
        a = 8'd9; b = 8'd9; dut = 8'd0;
        v_add = 1'b1;
        repeat (2) @(negedge clk);
        v_add = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (d_x[0]) n_done++;
        end
        check("rst_no_done", 32'(n_done), 0);
        check("rst_txn",     32'(t_x[0]), 0);
        check("rst_err",     32'(er_x[0]), 0);
        check("rst_fvalid",  32'(fv_x[0]), 0);

        @(negedge clk);
        a = 8'd10; b = 8'd20; dut = 8'd30;
        v_add = 1'b1;
        @(negedge clk);
        v_add = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_early", 32'(d_x[0]), 0);
        @(negedge clk);
        check("post_rst_done",  32'(d_x[0]), 1);
        check("post_rst_lane",  32'(l_x[0]), 0);
        check("post_rst_event", 32'(e_x[0]), 0);
        check("post_rst_txn",   32'(t_x[0]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_lane_checker.md
Name: rr_lane_checker

Overview:
- Parametrised successor to the round-robin output monitor. Accepts DUT transactions (operands plus DUT result) under a valid/ready handshake and distributes them round-robin over NUM_LANES checker lanes.
- Each lane computes the golden result over a fixed LANE_LAT-cycle latency and compares it against the DUT result.
- Reports per-transaction completion and mismatch, keeps saturating transaction and error counters, and captures the first failing transaction.
- Sits between the DUT output stage and the testbench scoreboard/status registers.

Parameters:
- WIDTH, 32, operand/result width.
- NUM_LANES, 4, number of checker lanes (>=1).
- LANE_LAT, 3, cycles from accept to retire (>=1).
- MODE, 0, golden operation: 0 = a+b, 1 = a-b, 2 = a*b; all results mod 2^WIDTH, low WIDTH bits.
- CNT_WIDTH, 16, width of the event counters.
- LANE_W, max(1,$clog2(NUM_LANES)), lane index width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_valid  in  1  transaction present
- o_ready  out  1  target lane can accept
- i_a  in  WIDTH  operand a
- i_b  in  WIDTH  operand b
- i_dut_o  in  WIDTH  DUT result for (a,b)
- i_clear  in  1  synchronous clear of counters and capture
- o_done  out  1  one-cycle pulse, a transaction retired
- o_event  out  1  one-cycle pulse, retired transaction mismatched
- o_lane  out  LANE_W  lane of the retiring transaction (valid with o_done)
- o_txn_count  out  CNT_WIDTH  retired transactions, saturating
- o_err_count  out  CNT_WIDTH  mismatches, saturating
- o_first_valid  out  1  capture registers hold a failure
- o_first_a / o_first_b / o_first_dut / o_first_exp  out  WIDTH each  first failing a, b, DUT result, golden result

Behaviour:
- Reset clears all outputs, counters, capture registers, lane busy flags and lane data to 0. Lane pointer resets to lane 0.
- Reset mid-operation discards in-flight transactions; no o_done is produced for them.
- Accept occurs when i_valid && o_ready at a clk edge.
  - Operands are latched into the lane at the pointer.
  - That lane goes busy with its down-counter set to LANE_LAT.
  - Pointer advances to (ptr+1) mod NUM_LANES.
  - Pointer never advances without an accept.
- Busy lanes decrement their counter every cycle. A lane retires at the edge exactly LANE_LAT cycles after its accept edge. At that edge:
  - o_done=1 and o_lane=lane index, both registered.
  - o_event = (golden != dut).
  - The busy flag clears.
- o_ready = ~busy[ptr] | (busy[ptr] && counter[ptr]==1). A lane may re-accept on its retire edge.
- With NUM_LANES >= LANE_LAT, o_ready stays 1 and throughput is one transaction per cycle.
- Equal latency plus at most one accept per cycle means at most one retire per cycle, and retire order equals accept order.
- i_valid with o_ready=0 is not accepted. The source must hold its data. No input buffering.
- Counters:
  - On retire, o_txn_count increments.
  - On mismatch, o_err_count increments.
  - Each counter saturates at all-ones and never wraps.
- Capture:
  - On a mismatch while o_first_valid=0, load a, b, dut and golden, and set o_first_valid.
  - Later mismatches do not overwrite the capture.
- i_clear zeroes both counters, o_first_valid and the capture registers. It does not affect lanes, pointer, or o_done/o_event.
- If i_clear coincides with a retire, clear wins: the retire is not counted or captured, but o_done/o_event still pulse.
- Arithmetic is modular WIDTH-bit. Overflow and borrow are discarded and are not mismatches.

Test Plan:
- WIDTH=8, NUM_LANES=4, LANE_LAT=3, MODE=0; accept a=3,b=4,dut=7 at edge T -> o_done=1,o_event=0,o_lane=0 at T+3; o_txn_count=1, o_err_count=0.
- Same config; a=3,b=4,dut=8 -> o_event=1 at T+3; o_first_valid=1, first_exp=7, first_dut=8. A second mismatch a=1,b=1,dut=5 -> o_err_count=2, capture unchanged.
- MODE=0 a=200,b=100,dut=44 -> no event. MODE=1 a=5,b=10,dut=251 -> no event. MODE=2 a=16,b=17,dut=16 -> no event.
- NUM_LANES=2, LANE_LAT=4, i_valid held high for 8 cycles -> accepts at cycles 0,1,4,5; o_ready=0 in cycles 2,3,6,7; o_lane sequence 0,1,0,1.
- CNT_WIDTH=2; five mismatching transactions -> o_err_count and o_txn_count stop at 3. i_clear on the cycle of a sixth retire -> both counters 0 and o_first_valid=0, while o_done still pulses.
- Reset asserted one cycle after two accepts -> no o_done afterwards, counters 0. Next accept goes to lane 0 and retires normally LANE_LAT cycles later.
